// File: rtl/enc_pkg.sv
// Shared types and helpers for the 8-to-3 streaming encoder.
// Optional zero-vector beat is enabled by defining ENC_ZERO_BEAT_EN.
package enc_pkg;

    localparam int N_IN  = 8;
    localparam int W_OUT = 3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // True when exactly one bit of v is set.
    function automatic logic popcount_is_one(input logic [N_IN-1:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/encoder_8to3_stream_prio8.sv
// Combinational 8-to-3 priority encoder, direction selected by msb_first.
// Unaffected by ENC_ZERO_BEAT_EN.
module enc_prio8
    import enc_pkg::*;
(
    input  logic [N_IN-1:0]  vec,
    input  logic             msb_first,
    output logic [W_OUT-1:0] idx,
    output logic             found
);

    logic [W_OUT-1:0] k;

    // Scan towards the winning end so the last hit seen has priority.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            k = msb_first ? W_OUT'(i) : W_OUT'(N_IN - 1 - i);
            if (vec[k]) begin
                idx   = k;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/encoder_8to3_stream.sv
// Streaming 8-to-3 encoder: accepts a multi-hot vector and emits the index
// of every set bit, one per beat, in priority order.
// Define ENC_ZERO_BEAT_EN to turn an all-zero vector into a single y_zero beat.
module encoder_8to3_stream #(
    parameter int MSB_FIRST = 1,
    parameter int N_IN      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_IN-1:0]           in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [enc_pkg::W_OUT-1:0] y,
    output logic                      y_valid,
    input  logic                      y_ready,
    output logic                      y_last,
`ifdef ENC_ZERO_BEAT_EN
    output logic                      y_zero,
`endif
    output logic                      busy
);

    import enc_pkg::*;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   pend_q, pend_d;
    logic [W_OUT-1:0]  idx;
    logic              found;
    logic              emit;
    logic              last;
    logic              accept;
    logic              fire;
`ifdef ENC_ZERO_BEAT_EN
    logic              zero_q, zero_d;
`endif

    enc_prio8 u_prio (
        .vec       (pend_q),
        .msb_first (MSB_FIRST != 0),
        .idx       (idx),
        .found     (found)
    );

    assign emit = (state_q == ST_EMIT);
`ifdef ENC_ZERO_BEAT_EN
    assign last = emit & (popcount_is_one(pend_q) | zero_q);
    assign y_zero = emit & zero_q;
`else
    assign last = emit & popcount_is_one(pend_q);
`endif

    // Registered-only outputs plus the single y_ready -> in_ready path.
    always_comb begin
        y        = emit ? idx : '0;
        y_valid  = emit;
        y_last   = last;
        busy     = emit;
        in_ready = ~rst & (~emit | (last & y_ready));
        accept   = in_valid & in_ready;
        fire     = emit & y_ready;
    end

    // Next state: retire the current beat first, then a same-cycle accept
    // overrides the return to IDLE so vectors stream back-to-back.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
`ifdef ENC_ZERO_BEAT_EN
        zero_d  = zero_q;
`endif
        if (fire) begin
            if (found) begin
                pend_d = pend_q & ~(N_IN'(1) << idx);
            end
            if (last) begin
                state_d = ST_IDLE;
`ifdef ENC_ZERO_BEAT_EN
                zero_d  = 1'b0;
`endif
            end
        end
        if (accept) begin
            if (in != '0) begin
                pend_d  = in;
                state_d = ST_EMIT;
`ifdef ENC_ZERO_BEAT_EN
                zero_d  = 1'b0;
`endif
            end
`ifdef ENC_ZERO_BEAT_EN
            else begin
                pend_d  = '0;
                state_d = ST_EMIT;
                zero_d  = 1'b1;
            end
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
`ifdef ENC_ZERO_BEAT_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
`ifdef ENC_ZERO_BEAT_EN
            zero_q  <= zero_d;
`endif
        end
    end

endmodule

// File: doc/encoder_8to3_stream.md
Name: encoder_8to3_stream

Overview:
- Sequential counterpart of the team's 3-to-8 decoder: accepts an 8-bit multi-hot vector and emits the 3-bit index of every set bit, one code per beat, in priority order.
- Sits between request-collection logic, such as interrupt or event lines, and a consumer that handles one indexed event at a time.
- Valid/ready handshake on both sides.

Parameters:
- MSB_FIRST, 1: 1 = emit highest set index first; 0 = emit lowest set index first.
- N_IN, 8: input vector width. Fixed at 8; W_OUT = 3 is a derived localparam.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  8  request vector, sampled on accept.
- in_valid  input  1  vector presented.
- in_ready  output  1  block can accept a vector this cycle.
- y  output  3  encoded index of the current set bit.
- y_valid  output  1  y is valid.
- y_ready  input  1  consumer accepts y.
- y_last  output  1  current beat is the final code of this vector.
- busy  output  1  pending bits remain (state EMIT).

Behaviour:
- Reset: rst high at a clk edge forces state IDLE, pend=8'h00, y_valid=0, y=3'd0, y_last=0, busy=0.
  - in_ready reads 0 while rst is high and 1 in the first cycle after release.
  - Reset mid-EMIT discards all pending bits; no further beats are emitted.
- State machine, 2 states:
  - IDLE:
    - in_ready=1.
    - On in_valid & in_ready with in != 0: pend <= in, go to EMIT.
    - With in == 0: vector accepted and dropped, stay IDLE (see optional feature).
  - EMIT:
    - y_valid=1, busy=1.
    - y = priority index of pend per MSB_FIRST.
    - y_last = 1 when pend has exactly one bit set.
    - On y_valid & y_ready: clear bit y in pend.
    - If y_last, go to IDLE, unless a new vector is accepted the same cycle (below).
- Outputs y, y_valid, y_last and busy are functions of registers only, with no combinational path from inputs.
- in_ready = (state==IDLE) | (state==EMIT & y_last & y_ready). This is the only combinational input-to-output path (y_ready to in_ready).
  - It gives back-to-back vectors: the final beat of vector A and the accept of vector B happen in the same cycle; B's first beat appears the next cycle.
- Latency: vector accepted at edge N gives first y_valid at cycle N+1.
  - With y_ready held high: one code per cycle, popcount(in) cycles per vector.
- Backpressure: y_ready=0 holds y, y_valid and y_last stable; pend is unchanged.
- in is sampled only on accept; later changes to in do not affect pending codes.
- Vector 8'hFF gives 8 beats (7..0 when MSB_FIRST=1); y_last only on the 8th.

Optional Feature:
- Macro: ENC_ZERO_BEAT_EN.
- Defined:
  - An accepted all-zero vector produces exactly one beat with y=3'd0, y_last=1, and output y_zero=1.
  - y_zero is an extra 1-bit output port, 0 on every other beat and after reset.
  - The beat is held under backpressure like any other beat.
- Undefined: all-zero vectors are accepted and silently dropped, no beat is produced, and the y_zero port does not exist.

Decomposition:
- Package enc_pkg holds:
  - localparams N_IN=8, W_OUT=3;
  - state typedef {ST_IDLE, ST_EMIT};
  - function popcount_is_one(8-bit).
- Sub-module enc_prio8: purely combinational 8-to-3 priority encoder.
  - Inputs: vec[7:0], msb_first.
  - Outputs: idx[2:0], found.
  - Instantiated once on pend.

Test Plan:
- Reset: assert rst mid-EMIT after in=8'hA5 is accepted -> next cycle y_valid=0, busy=0, pend cleared; after release in_ready=1 and no stale beats.
- Basic, MSB_FIRST=1, y_ready=1: in=8'b1001_0010 -> y=7,4,1 on three consecutive cycles; y_last=1 only with y=1; in_ready=1 on that cycle.
- Order, MSB_FIRST=0: in=8'h81 -> y=0 then y=7 with y_last=1.
- Backpressure: in=8'h06, y_ready low for 3 cycles -> y=2 held stable with y_valid=1; then y_ready=1 -> y=2, then y=1 with y_last.
- Back-to-back: vector A=8'h01, then B=8'h80 presented continuously -> A's final beat and B's accept occur in the same cycle; y=0 (last) is followed immediately by y=7 (last) with no idle cycle.
- Zero vector: in=8'h00 -> default build: accepted, no beat, in_ready stays 1; ENC_ZERO_BEAT_EN build: one beat y=0, y_zero=1, y_last=1.
